// File: rtl/nn_bg_pkg.sv
// rtl/nn_bg_pkg.sv - shared types and gate-index helper for the burst-gate phase scheduler
package nn_bg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_DRAIN
    } state_t;

    localparam int NGATES_MAX = 8;
    localparam int IDX_W      = 3;

    // Circular search starting after cur; cur itself is the last candidate.
    // Returns cur unchanged when no gate in the mask is enabled.
    function automatic logic [IDX_W-1:0] next_enabled(
        input logic [IDX_W-1:0]      cur,
        input logic [NGATES_MAX-1:0] mask,
        input int                    ngates
    );
        logic [IDX_W-1:0] sel;
        logic [IDX_W-1:0] idx_w;
        logic             found;
        int               idx;
        sel   = cur;
        found = 1'b0;
        for (int k = 1; k <= NGATES_MAX; k++) begin
            idx   = (int'(cur) + k) % ngates;
            idx_w = IDX_W'(idx);
            if (!found && (k <= ngates) && mask[idx_w]) begin
                sel   = idx_w;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/nn_bg_vote.sv
// rtl/nn_bg_vote.sv - masked unanimous vote of burst outputs with hold and INIT load
module nn_bg_vote #(
    parameter int N = 3
) (
    input  logic         CLK,
    input  logic         RSTn,
    input  logic         init_load,
    input  logic         vote_en,
    input  logic         init_state,
    input  logic [N-1:0] burst,
    input  logic [N-1:0] mask,
    output logic         out
);

    logic [N-1:0] hits;

    assign hits = burst & mask;

    // A split vote, or no participating gate, keeps the previous decision.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            out <= 1'b0;
        end else if (init_load) begin
            out <= init_state;
        end else if (vote_en && (|mask)) begin
            if (hits == mask) begin
                out <= 1'b1;
            end else if (hits == '0) begin
                out <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/nn_bg_phase_sched.sv
// rtl/nn_bg_phase_sched.sv - round-robin gate enable and INIT sequencer; NN_BG_GATE_MASK_EN enables GATE_MASK
module nn_bg_phase_sched
    import nn_bg_pkg::*;
#(
    parameter  int NGATES      = 3,
    parameter  int INIT_CYCLES = 4,
    localparam int PW          = $clog2(NGATES)
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              START,
    input  logic              STOP,
    input  logic              INIT_STATE,
    input  logic [NGATES-1:0] GATE_MASK,
    input  logic [NGATES-1:0] BURST_OUT,
    output logic [NGATES-1:0] GATE_EN,
    output logic              GATE_INIT,
    output logic              OUT,
    output logic [PW-1:0]     PHASE,
    output logic              BUSY
);

    localparam int CW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [NGATES-1:0] GATE_ONE = NGATES'(1);

    state_t            state, state_n;
    logic [CW-1:0]     init_cnt, init_cnt_n;
    logic [PW-1:0]     phase_n;
    logic [NGATES-1:0] gate_en_n;
    logic              gate_init_n;
    logic [NGATES-1:0] eff_mask;
    logic [IDX_W-1:0]  nxt, first;
    logic              any_en, wrap;

`ifdef NN_BG_GATE_MASK_EN
    assign eff_mask = GATE_MASK;
`else
    logic unused_gate_mask;
    assign unused_gate_mask = ^GATE_MASK;
    assign eff_mask         = '1;
`endif

    assign any_en = |eff_mask;
    assign nxt    = next_enabled(IDX_W'(PHASE), NGATES_MAX'(eff_mask), NGATES);
    assign first  = next_enabled(IDX_W'(NGATES - 1), NGATES_MAX'(eff_mask), NGATES);
    // The next visit lands at or below the current gate: this round is complete.
    assign wrap   = any_en && (nxt <= IDX_W'(PHASE));
    assign BUSY   = (state != ST_IDLE);

    always_comb begin
        state_n     = state;
        init_cnt_n  = init_cnt;
        phase_n     = PHASE;
        gate_en_n   = '0;
        gate_init_n = 1'b0;
        unique case (state)
            ST_IDLE: begin
                phase_n = '0;
                if (START && !STOP) begin
                    state_n     = ST_INIT;
                    init_cnt_n  = CW'(INIT_CYCLES - 1);
                    gate_en_n   = '1;
                    gate_init_n = 1'b1;
                end
            end
            ST_INIT: begin
                if (STOP) begin
                    state_n = ST_IDLE;
                    phase_n = '0;
                end else if (init_cnt == '0) begin
                    state_n = ST_RUN;
                    if (any_en) begin
                        phase_n   = PW'(first);
                        gate_en_n = GATE_ONE << PW'(first);
                    end
                end else begin
                    init_cnt_n  = init_cnt - 1'b1;
                    gate_en_n   = '1;
                    gate_init_n = 1'b1;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if ((STOP || state == ST_DRAIN) && (!any_en || wrap)) begin
                    if (!any_en && state == ST_DRAIN && !STOP) begin
                        state_n = ST_DRAIN;
                    end else begin
                        state_n = ST_IDLE;
                        phase_n = '0;
                    end
                end else begin
                    if (STOP) begin
                        state_n = ST_DRAIN;
                    end
                    if (any_en) begin
                        phase_n   = PW'(nxt);
                        gate_en_n = GATE_ONE << PW'(nxt);
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                phase_n = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= ST_IDLE;
            init_cnt  <= '0;
            PHASE     <= '0;
            GATE_EN   <= '0;
            GATE_INIT <= 1'b0;
        end else begin
            state     <= state_n;
            init_cnt  <= init_cnt_n;
            PHASE     <= phase_n;
            GATE_EN   <= gate_en_n;
            GATE_INIT <= gate_init_n;
        end
    end

    nn_bg_vote #(
        .N(NGATES)
    ) u_vote (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .init_load  (state == ST_INIT),
        .vote_en    ((state == ST_RUN) || (state == ST_DRAIN)),
        .init_state (INIT_STATE),
        .burst      (BURST_OUT),
        .mask       (eff_mask),
        .out        (OUT)
    );

endmodule
